// File: rtl/recovery_pkg.sv
// rtl/recovery_pkg.sv - shared types and constants for the recovery fetch path
// Contents: word_t, fetch_tgt_e, ROM window defaults, window-decode helper.
package recovery_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {TGT_MEM, TGT_ROM} fetch_tgt_e;

  localparam word_t       ROM_BASE_DEFAULT = 32'h1A11_0800;
  localparam int unsigned ROM_SIZE_DEFAULT = 32;

  // Window test done as an offset compare so a window touching the top of
  // the address space cannot wrap into a false hit.
  function automatic logic in_window(input word_t addr, input word_t base, input word_t bytes);
    word_t off;
    off = addr - base;
    return (addr >= base) && (off < bytes);
  endfunction

endpackage

// File: rtl/fetch_outstanding_ctr.sv
// rtl/fetch_outstanding_ctr.sv - checked up/down counter of in-flight fetches
// Ports: clk_i, rst_i (async, active-high); inc/dec step requests;
//        count (3 bits), full (count == MAX), empty (count == 0),
//        err pulses on an overflow or underflow attempt (count then holds).
module fetch_outstanding_ctr #(
  parameter int unsigned MAX = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       full,
  output logic       empty,
  output logic       err
);

  localparam logic [2:0] MAX_C = 3'(MAX);

  logic [2:0] count_q;
  logic       overflow;
  logic       underflow;

  // Simultaneous inc and dec cancel, so only a lone step can go out of range.
  assign overflow  = inc && !dec && (count_q == MAX_C);
  assign underflow = dec && !inc && (count_q == 3'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (inc && !dec && !overflow) begin
      count_q <= count_q + 3'd1;
    end else if (dec && !inc && !underflow) begin
      count_q <= count_q - 3'd1;
    end
  end

  assign count = count_q;
  assign full  = (count_q == MAX_C);
  assign empty = (count_q == 3'd0);
  assign err   = overflow || underflow;

endmodule

// File: rtl/recovery_fetch_router.sv
// rtl/recovery_fetch_router.sv - routes core fetches to main memory or recovery ROM
// Ports: clk_i, rst_i (async, active-high)
//        core:  instr_req_i, instr_addr_i -> instr_gnt_o, instr_rvalid_o, instr_rdata_o
//        mem:   mem_req_o, mem_addr_o, mem_gnt_i, mem_rvalid_i, mem_rdata_i
//        rom:   rom_req_o, rom_addr_o (offset into window), rom_rdata_i (1-cycle latency)
//        err_o: sticky protocol-error flag
module recovery_fetch_router
  import recovery_pkg::*;
#(
  parameter word_t       ROM_BASE        = ROM_BASE_DEFAULT,
  parameter int unsigned ROM_SIZE        = ROM_SIZE_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_rdata_i,
  output logic        err_o
);

  localparam word_t ROM_BYTES = word_t'(ROM_SIZE) << 2;

  fetch_tgt_e req_tgt;
  fetch_tgt_e last_tgt_q;
  logic       rom_pending_q;
  logic       err_q;
  word_t      rdata_q;

  logic [2:0] cnt;
  logic       cnt_full;
  logic       cnt_empty;
  logic       cnt_err;
  logic       cnt_unused;

  logic       stall;
  logic       mem_resp;
  logic       spurious;

  assign req_tgt = in_window(instr_addr_i, ROM_BASE, ROM_BYTES) ? TGT_ROM : TGT_MEM;

  // A target switch waits for the pipe to drain; that alone keeps the two
  // sources' responses in request order.
  assign stall = cnt_full || (!cnt_empty && (req_tgt != last_tgt_q));

  // Request side is gated by rst_i so the handshake is quiet during reset
  // even if the core and memory keep driving.
  always_comb begin
    mem_req_o   = 1'b0;
    rom_req_o   = 1'b0;
    instr_gnt_o = 1'b0;
    if (!rst_i && instr_req_i && !stall) begin
      if (req_tgt == TGT_ROM) begin
        rom_req_o   = 1'b1;
        instr_gnt_o = 1'b1;
      end else begin
        mem_req_o   = 1'b1;
        instr_gnt_o = mem_gnt_i;
      end
    end
  end

  assign mem_addr_o = instr_addr_i;
  assign rom_addr_o = instr_addr_i - ROM_BASE;

  // A memory beat is only legitimate while a MEM fetch is in flight.
  assign mem_resp = mem_rvalid_i && (last_tgt_q == TGT_MEM) && !cnt_empty;
  assign spurious = mem_rvalid_i && !mem_resp;

  assign instr_rvalid_o = rom_pending_q || mem_resp;

  always_comb begin
    instr_rdata_o = rdata_q;
    if (rom_pending_q) begin
      instr_rdata_o = rom_rdata_i;
    end else if (mem_resp) begin
      instr_rdata_o = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_tgt_q    <= TGT_MEM;
      rom_pending_q <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      rom_pending_q <= rom_req_o;
      if (instr_gnt_o) begin
        last_tgt_q <= req_tgt;
      end
      if (instr_rvalid_o) begin
        rdata_q <= instr_rdata_o;
      end
      if (spurious || cnt_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

  fetch_outstanding_ctr #(
    .MAX (MAX_OUTSTANDING)
  ) u_ctr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc   (instr_gnt_o),
    .dec   (instr_rvalid_o),
    .count (cnt),
    .full  (cnt_full),
    .empty (cnt_empty),
    .err   (cnt_err)
  );

  // Raw count is only observed through full/empty here.
  assign cnt_unused = ^cnt;

endmodule

// File: tb/tb_recovery_fetch_router.sv
// tb/tb_recovery_fetch_router.sv - self-checking bench for recovery_fetch_router
module tb_recovery_fetch_router;
  import recovery_pkg::*;

  localparam word_t BASE = 32'h1A11_0800;
  localparam int    MAXO = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_rdata_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  recovery_fetch_router #(
    .ROM_BASE        (BASE),
    .ROM_SIZE        (32),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_addr_o     (mem_addr_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .rom_req_o      (rom_req_o),
    .rom_addr_o     (rom_addr_o),
    .rom_rdata_i    (rom_rdata_i),
    .err_o          (err_o)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference decode with wide arithmetic: window is [BASE, BASE + 4*32).
  function automatic bit ref_is_rom(input word_t a);
    longint unsigned la;
    la = a;
    return (la >= longint'(BASE)) && (la < longint'(BASE) + 128);
  endfunction

  function automatic word_t rand_addr();
    case ($urandom_range(0, 5))
      0, 1:    return BASE + 4 * $urandom_range(0, 31);
      2:       return BASE - 32'd4;
      3:       return BASE + 32'h80;
      4:       return 32'hFFFF_FFFC;
      default: return $urandom() & 32'h0000_FFFC;
    endcase
  endfunction

  // Reference model state for the random phase
  int         cnt;
  fetch_tgt_e last, tgt;
  bit         rom_due, pend, is_rom, ok;
  bit         e_gnt, e_memreq, e_romreq, e_rv;
  word_t      e_rd, last_rdata, paddr;
  word_t      mem_q[$];

  initial begin
    rst_i        = 1'b1;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h100;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    rom_rdata_i  = '0;

    // Reset state, with the core and memory driving a handshake
    tick(); tick(); #4;
    chk("reset_gnt", instr_gnt_o, 0);
    chk("reset_rvalid", instr_rvalid_o, 0);
    chk("reset_rdata", instr_rdata_o, 0);
    chk("reset_mem_req", mem_req_o, 0);
    chk("reset_rom_req", rom_req_o, 0);
    chk("reset_err", err_o, 0);
    tick();
    rst_i = 1'b0; instr_req_i = 1'b0; mem_gnt_i = 1'b0;

    // ROM fetch
    instr_req_i = 1'b1; instr_addr_i = 32'h1A11_0808; rom_rdata_i = 32'hFFFF_FFFF;
    #4;
    chk("rom_gnt", instr_gnt_o, 1);
    chk("rom_req", rom_req_o, 1);
    chk("rom_addr", rom_addr_o, 32'h8);
    chk("rom_no_mem_req", mem_req_o, 0);
    chk("rom_rvalid_c0", instr_rvalid_o, 0);
    tick();
    instr_req_i = 1'b0; rom_rdata_i = 32'h00B1_0113;
    #4;
    chk("rom_rvalid_c1", instr_rvalid_o, 1);
    chk("rom_rdata_c1", instr_rdata_o, 32'h00B1_0113);
    tick();
    rom_rdata_i = 32'h1234_5678;
    #4;
    chk("rom_rvalid_c2", instr_rvalid_o, 0);
    chk("rom_rdata_hold", instr_rdata_o, 32'h00B1_0113);
    tick();

    // MEM fetch, grant delayed two cycles, response three cycles after grant
    instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b0;
    #4;
    chk("mem_req", mem_req_o, 1);
    chk("mem_addr", mem_addr_o, 32'h100);
    chk("mem_gnt_wait0", instr_gnt_o, 0);
    chk("mem_no_rom_req", rom_req_o, 0);
    tick(); #4;
    chk("mem_gnt_wait1", instr_gnt_o, 0);
    tick();
    mem_gnt_i = 1'b1;
    #4;
    chk("mem_gnt", instr_gnt_o, 1);
    tick();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    #4;
    chk("mem_rvalid_early", instr_rvalid_o, 0);
    tick(); tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    #4;
    chk("mem_rvalid", instr_rvalid_o, 1);
    chk("mem_rdata", instr_rdata_o, 32'hCAFE_F00D);
    chk("mem_resp_no_rom_req", rom_req_o, 0);
    tick();
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    #4;
    chk("mem_rvalid_drop", instr_rvalid_o, 0);
    chk("mem_rdata_hold", instr_rdata_o, 32'hCAFE_F00D);
    tick();

    // Boundary decode
    instr_req_i = 1'b1; instr_addr_i = 32'h1A11_087C;
    #4;
    chk("bnd_last_word_rom", rom_req_o, 1);
    chk("bnd_last_word_gnt", instr_gnt_o, 1);
    chk("bnd_last_word_off", rom_addr_o, 32'h7C);
    tick();
    instr_req_i = 1'b0; rom_rdata_i = 32'h0BAD_0BAD;
    #4;
    chk("bnd_rom_rdata", instr_rdata_o, 32'h0BAD_0BAD);
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h1A11_0880; mem_gnt_i = 1'b0;
    #2;
    chk("bnd_end_mem", mem_req_o, 1);
    chk("bnd_end_not_rom", rom_req_o, 0);
    instr_addr_i = 32'h1A11_07FC;
    #2;
    chk("bnd_below_mem", mem_req_o, 1);
    chk("bnd_below_not_rom", rom_req_o, 0);
    tick();
    instr_req_i = 1'b0;

    // Ordering: ROM request waits behind an outstanding MEM fetch
    instr_req_i = 1'b1; instr_addr_i = 32'h200; mem_gnt_i = 1'b1;
    #4;
    chk("ord_mem_gnt", instr_gnt_o, 1);
    tick();
    mem_gnt_i = 1'b0; instr_addr_i = 32'h1A11_0810;
    #4;
    chk("ord_rom_stall0", instr_gnt_o, 0);
    chk("ord_rom_req0", rom_req_o, 0);
    tick(); #4;
    chk("ord_rom_stall1", instr_gnt_o, 0);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    #4;
    chk("ord_mem_rvalid", instr_rvalid_o, 1);
    chk("ord_mem_rdata", instr_rdata_o, 32'h1111_2222);
    chk("ord_no_bypass", instr_gnt_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    #4;
    chk("ord_rom_gnt", instr_gnt_o, 1);
    chk("ord_rom_req", rom_req_o, 1);
    tick();
    instr_req_i = 1'b0; rom_rdata_i = 32'h3333_4444;
    #4;
    chk("ord_rom_rvalid", instr_rvalid_o, 1);
    chk("ord_rom_rdata", instr_rdata_o, 32'h3333_4444);
    tick();

    // Back-to-back ROM fetches
    instr_req_i = 1'b1; instr_addr_i = 32'h1A11_0800;
    #4;
    chk("b2b_gnt0", instr_gnt_o, 1);
    tick();
    instr_addr_i = 32'h1A11_0804; rom_rdata_i = 32'hA0A0_0000;
    #4;
    chk("b2b_gnt1", instr_gnt_o, 1);
    chk("b2b_rdata0", instr_rdata_o, 32'hA0A0_0000);
    tick();
    instr_addr_i = 32'h1A11_0808; rom_rdata_i = 32'hA0A0_0001;
    #4;
    chk("b2b_gnt2", instr_gnt_o, 1);
    chk("b2b_rvalid1", instr_rvalid_o, 1);
    chk("b2b_rdata1", instr_rdata_o, 32'hA0A0_0001);
    tick();
    instr_req_i = 1'b0; rom_rdata_i = 32'hA0A0_0002;
    #4;
    chk("b2b_rdata2", instr_rdata_o, 32'hA0A0_0002);
    tick(); #4;
    chk("b2b_idle", instr_rvalid_o, 0);
    tick();

    // Outstanding limit on MEM, no same-cycle bypass
    instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
    #4;
    chk("full_gnt0", instr_gnt_o, 1);
    tick();
    instr_addr_i = 32'h304;
    #4;
    chk("full_gnt1", instr_gnt_o, 1);
    tick();
    instr_addr_i = 32'h308;
    #4;
    chk("full_stall_gnt", instr_gnt_o, 0);
    chk("full_stall_req", mem_req_o, 0);
    tick();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5000_0000;
    #4;
    chk("full_no_bypass", instr_gnt_o, 0);
    chk("full_rvalid0", instr_rvalid_o, 1);
    tick();
    mem_rvalid_i = 1'b0;
    #4;
    chk("full_gnt2", instr_gnt_o, 1);
    tick();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5000_0001;
    #4;
    chk("full_rdata1", instr_rdata_o, 32'h5000_0001);
    tick();
    mem_rdata_i = 32'h5000_0002;
    #4;
    chk("full_rdata2", instr_rdata_o, 32'h5000_0002);
    tick();
    mem_rvalid_i = 1'b0;
    #4;
    chk("full_err_clean", err_o, 0);
    tick();

    // Spurious memory beat, then reset mid-stream
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_0001;
    #4;
    chk("spur_not_fwd", instr_rvalid_o, 0);
    chk("spur_rdata_hold", instr_rdata_o, 32'h5000_0002);
    chk("spur_err_same_cycle", err_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    #4;
    chk("spur_err_set", err_o, 1);
    tick(); #4;
    chk("spur_err_sticky", err_o, 1);
    tick();
    instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
    #4;
    chk("rst_pre_gnt", instr_gnt_o, 1);
    tick();
    instr_addr_i = 32'h404;
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_async_err", err_o, 0);
    chk("rst_async_gnt", instr_gnt_o, 0);
    chk("rst_async_mem_req", mem_req_o, 0);
    chk("rst_async_rvalid", instr_rvalid_o, 0);
    chk("rst_async_rdata", instr_rdata_o, 0);
    tick();
    rst_i = 1'b0; instr_req_i = 1'b0; mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_0002;
    #4;
    chk("rst_stale_not_fwd", instr_rvalid_o, 0);
    tick();
    mem_rvalid_i = 1'b0;
    #4;
    chk("rst_stale_err", err_o, 1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #4;
    chk("rst_clear_err", err_o, 0);
    tick();

    // Randomized traffic against a queue-based reference model
    cnt = 0; last = TGT_MEM; rom_due = 1'b0; pend = 1'b0;
    last_rdata = '0; paddr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend  = 1'b1;
        paddr = rand_addr();
      end
      instr_req_i  = pend;
      instr_addr_i = pend ? paddr : $urandom();
      mem_gnt_i    = ($urandom_range(0, 2) != 0);
      mem_rvalid_i = (mem_q.size() > 0) && ($urandom_range(0, 1) == 1);
      mem_rdata_i  = mem_rvalid_i ? mem_q[0] : $urandom();
      rom_rdata_i  = $urandom();

      is_rom   = ref_is_rom(instr_addr_i);
      tgt      = is_rom ? TGT_ROM : TGT_MEM;
      ok       = pend && (cnt < MAXO) && ((cnt == 0) || (tgt == last));
      e_gnt    = ok && (is_rom || mem_gnt_i);
      e_memreq = ok && !is_rom;
      e_romreq = ok && is_rom;
      e_rv     = rom_due || mem_rvalid_i;
      e_rd     = rom_due ? rom_rdata_i : (mem_rvalid_i ? mem_rdata_i : last_rdata);

      #4;
      chk("rnd_gnt", instr_gnt_o, e_gnt);
      chk("rnd_mem_req", mem_req_o, e_memreq);
      chk("rnd_rom_req", rom_req_o, e_romreq);
      chk("rnd_rvalid", instr_rvalid_o, e_rv);
      chk("rnd_rdata", instr_rdata_o, e_rd);
      chk("rnd_err", err_o, 0);
      if (e_romreq) chk("rnd_rom_addr", rom_addr_o, paddr - BASE);
      if (e_memreq) chk("rnd_mem_addr", mem_addr_o, paddr);

      if (e_rv) begin
        cnt--;
        if (!rom_due) void'(mem_q.pop_front());
        last_rdata = e_rd;
      end
      rom_due = e_gnt && is_rom;
      if (e_gnt) begin
        cnt++;
        last = tgt;
        pend = 1'b0;
        if (!is_rom) mem_q.push_back($urandom());
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
